// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage : ID->EX pipeline register feeding the ALU.
//
// Latches one decoded instruction (single-entry valid/ready stage), resolves
// operand forwarding from the MEM and WB stages at capture time, selects
// PC/immediate operand sources, and keeps re-applying forwarding to a held
// instruction while EX is stalled. flush_i kills both the held and the
// incoming instruction.
//
// Ports:
//   clk_i, rst_n_i                   clock, async active-low reset
//   id_valid_i / id_ready_o          decode handshake
//   flush_i                          kill held + incoming instruction
//   pc_i, imm_i                      instruction PC / sign-extended immediate
//   rs1_*_i, rs2_*_i                 regfile read data and source addresses
//   rd_addr_i, rd_we_i               destination register / write enable
//   alu_op_i                         ALU operation
//   src1_is_pc_i, src2_is_imm_i      operand source selects
//   mem_fwd_*_i, wb_fwd_*_i          MEM / WB result bypass ports
//   ex_valid_o / ex_ready_i          EX handshake
//   alu_op1_o, alu_op2_o             ALU operands
//   alu_operation_o                  ALU operation
//   store_data_o                     forwarded rs2 value for stores
//   pc_o, rd_addr_o, rd_we_o         carried-along instruction fields
//
// Configuration macro:
//   ID_EX_PERF_EN  adds stall_cnt_o / flush_cnt_o 32-bit wrapping counters.
// -----------------------------------------------------------------------------

package id_ex_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_operation_t;
endpackage

module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                id_valid_i,
  output logic                id_ready_o,
  input  logic                flush_i,
  input  logic [DWIDTH-1:0]   pc_i,
  input  logic [DWIDTH-1:0]   imm_i,
  input  logic [DWIDTH-1:0]   rs1_data_i,
  input  logic [DWIDTH-1:0]   rs2_data_i,
  input  logic [RADDR_W-1:0]  rs1_addr_i,
  input  logic [RADDR_W-1:0]  rs2_addr_i,
  input  logic [RADDR_W-1:0]  rd_addr_i,
  input  logic                rd_we_i,
  input  alu_operation_t      alu_op_i,
  input  logic                src1_is_pc_i,
  input  logic                src2_is_imm_i,
  input  logic                mem_fwd_we_i,
  input  logic [RADDR_W-1:0]  mem_fwd_addr_i,
  input  logic [DWIDTH-1:0]   mem_fwd_data_i,
  input  logic                wb_fwd_we_i,
  input  logic [RADDR_W-1:0]  wb_fwd_addr_i,
  input  logic [DWIDTH-1:0]   wb_fwd_data_i,
  output logic                ex_valid_o,
  input  logic                ex_ready_i,
  output logic [DWIDTH-1:0]   alu_op1_o,
  output logic [DWIDTH-1:0]   alu_op2_o,
  output alu_operation_t      alu_operation_o,
  output logic [DWIDTH-1:0]   store_data_o,
  output logic [DWIDTH-1:0]   pc_o,
  output logic [RADDR_W-1:0]  rd_addr_o,
  output logic                rd_we_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
`endif
);

  // Bypass resolution: MEM beats WB; x0 is never forwarded. When nothing
  // matches, the supplied fallback is returned (regfile data at capture,
  // the currently held value during a stall refresh).
  function automatic logic [DWIDTH-1:0] fwd_value(
    input logic [RADDR_W-1:0] addr,
    input logic [DWIDTH-1:0]  fallback,
    input logic               mem_we,
    input logic [RADDR_W-1:0] mem_addr,
    input logic [DWIDTH-1:0]  mem_data,
    input logic               wb_we,
    input logic [RADDR_W-1:0] wb_addr,
    input logic [DWIDTH-1:0]  wb_data
  );
    logic [DWIDTH-1:0] res;
    if (addr == {RADDR_W{1'b0}}) begin
      res = fallback;
    end else if (mem_we && (mem_addr == addr)) begin
      res = mem_data;
    end else if (wb_we && (wb_addr == addr)) begin
      res = wb_data;
    end else begin
      res = fallback;
    end
    return res;
  endfunction

  logic                valid_q, valid_d;
  logic [DWIDTH-1:0]   op1_q, op1_d;
  logic [DWIDTH-1:0]   op2_q, op2_d;
  logic [DWIDTH-1:0]   store_q, store_d;
  logic [DWIDTH-1:0]   pc_q, pc_d;
  logic [RADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic                rd_we_q, rd_we_d;
  alu_operation_t      alu_op_q, alu_op_d;
  logic [RADDR_W-1:0]  rs1_addr_q, rs1_addr_d;
  logic [RADDR_W-1:0]  rs2_addr_q, rs2_addr_d;
  // use flags: operand slot is sourced from a register (eligible for refresh)
  logic                use_rs1_q, use_rs1_d;
  logic                use_rs2_q, use_rs2_d;
  logic                accept_s;

  assign id_ready_o = ~valid_q | ex_ready_i;
  assign accept_s   = id_valid_i & id_ready_o;

  // Next-state selection: flush > accept > drain > hold-with-refresh.
  always_comb begin
    valid_d    = valid_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    store_d    = store_q;
    pc_d       = pc_q;
    rd_addr_d  = rd_addr_q;
    rd_we_d    = rd_we_q;
    alu_op_d   = alu_op_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    use_rs1_d  = use_rs1_q;
    use_rs2_d  = use_rs2_q;
    if (flush_i) begin
      valid_d = 1'b0;
      rd_we_d = 1'b0;
    end else if (accept_s) begin
      valid_d    = 1'b1;
      op1_d      = src1_is_pc_i ? pc_i :
                   fwd_value(rs1_addr_i, rs1_data_i, mem_fwd_we_i, mem_fwd_addr_i,
                             mem_fwd_data_i, wb_fwd_we_i, wb_fwd_addr_i, wb_fwd_data_i);
      store_d    = fwd_value(rs2_addr_i, rs2_data_i, mem_fwd_we_i, mem_fwd_addr_i,
                             mem_fwd_data_i, wb_fwd_we_i, wb_fwd_addr_i, wb_fwd_data_i);
      op2_d      = src2_is_imm_i ? imm_i : store_d;
      pc_d       = pc_i;
      rd_addr_d  = rd_addr_i;
      rd_we_d    = rd_we_i & (rd_addr_i != {RADDR_W{1'b0}});
      alu_op_d   = alu_op_i;
      rs1_addr_d = rs1_addr_i;
      rs2_addr_d = rs2_addr_i;
      use_rs1_d  = ~src1_is_pc_i;
      use_rs2_d  = ~src2_is_imm_i;
    end else if (valid_q && ex_ready_i) begin
      valid_d = 1'b0;
      rd_we_d = 1'b0;
    end else if (valid_q) begin
      // Stalled: pick up results that were still in flight at capture time.
      store_d = fwd_value(rs2_addr_q, store_q, mem_fwd_we_i, mem_fwd_addr_i,
                          mem_fwd_data_i, wb_fwd_we_i, wb_fwd_addr_i, wb_fwd_data_i);
      if (use_rs1_q) begin
        op1_d = fwd_value(rs1_addr_q, op1_q, mem_fwd_we_i, mem_fwd_addr_i,
                          mem_fwd_data_i, wb_fwd_we_i, wb_fwd_addr_i, wb_fwd_data_i);
      end else begin
        op1_d = op1_q;
      end
      if (use_rs2_q) begin
        op2_d = fwd_value(rs2_addr_q, op2_q, mem_fwd_we_i, mem_fwd_addr_i,
                          mem_fwd_data_i, wb_fwd_we_i, wb_fwd_addr_i, wb_fwd_data_i);
      end else begin
        op2_d = op2_q;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Stage state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q    <= 1'b0;
      op1_q      <= {DWIDTH{1'b0}};
      op2_q      <= {DWIDTH{1'b0}};
      store_q    <= {DWIDTH{1'b0}};
      pc_q       <= {DWIDTH{1'b0}};
      rd_addr_q  <= {RADDR_W{1'b0}};
      rd_we_q    <= 1'b0;
      alu_op_q   <= ALU_ADD;
      rs1_addr_q <= {RADDR_W{1'b0}};
      rs2_addr_q <= {RADDR_W{1'b0}};
      use_rs1_q  <= 1'b0;
      use_rs2_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      store_q    <= store_d;
      pc_q       <= pc_d;
      rd_addr_q  <= rd_addr_d;
      rd_we_q    <= rd_we_d;
      alu_op_q   <= alu_op_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      use_rs1_q  <= use_rs1_d;
      use_rs2_q  <= use_rs2_d;
    end
  end

  assign ex_valid_o      = valid_q;
  assign alu_op1_o       = op1_q;
  assign alu_op2_o       = op2_q;
  assign store_data_o    = store_q;
  assign pc_o            = pc_q;
  assign rd_addr_o       = rd_addr_q;
  assign rd_we_o         = rd_we_q;
  assign alu_operation_o = alu_op_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Performance counters; natural 32-bit wrap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (valid_q && !ex_ready_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (flush_i && valid_q) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage : self-checking bench for id_ex_stage (directed scenarios plus
// a randomized run against a behavioural reference model).
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
  import id_ex_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_ready, flush, ex_ready, ex_valid;
  logic [31:0] pc, imm, r1d, r2d, mfd, wfd;
  logic [4:0]  a1, a2, rd, mfa, wfa;
  logic rdwe, s1pc, s2imm, mfwe, wfwe;
  alu_operation_t aop, aop_o;
  logic [31:0] op1_o, op2_o, store_o, pc_o;
  logic [4:0]  rd_o;
  logic        rdwe_o;
`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DWIDTH(32), .RADDR_W(5)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_valid_i(id_valid), .id_ready_o(id_ready), .flush_i(flush),
    .pc_i(pc), .imm_i(imm), .rs1_data_i(r1d), .rs2_data_i(r2d),
    .rs1_addr_i(a1), .rs2_addr_i(a2), .rd_addr_i(rd), .rd_we_i(rdwe),
    .alu_op_i(aop), .src1_is_pc_i(s1pc), .src2_is_imm_i(s2imm),
    .mem_fwd_we_i(mfwe), .mem_fwd_addr_i(mfa), .mem_fwd_data_i(mfd),
    .wb_fwd_we_i(wfwe), .wb_fwd_addr_i(wfa), .wb_fwd_data_i(wfd),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .alu_op1_o(op1_o), .alu_op2_o(op2_o), .alu_operation_o(aop_o),
    .store_data_o(store_o), .pc_o(pc_o), .rd_addr_o(rd_o), .rd_we_o(rdwe_o)
`ifdef ID_EX_PERF_EN
    , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    pc = 32'd0; imm = 32'd0; r1d = 32'd0; r2d = 32'd0;
    a1 = 5'd0; a2 = 5'd0; rd = 5'd0; rdwe = 1'b0; aop = ALU_ADD;
    s1pc = 1'b0; s2imm = 1'b0;
    mfwe = 1'b0; mfa = 5'd0; mfd = 32'd0;
    wfwe = 1'b0; wfa = 5'd0; wfd = 32'd0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    #3;
    tests_run++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1 || aop_o !== ALU_ADD || op1_o !== 32'd0 ||
        op2_o !== 32'd0 || store_o !== 32'd0 || pc_o !== 32'd0 || rd_o !== 5'd0 || rdwe_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: valid=%b ready=%b op=%0d op1=%h op2=%h st=%h pc=%h rd=%0d we=%b, required 0/1/ADD/zeros",
               ex_valid, id_ready, aop_o, op1_o, op2_o, store_o, pc_o, rd_o, rdwe_o);
    end
`ifdef ID_EX_PERF_EN
    tests_run++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt: stall=%0d flush=%0d required 0/0", stall_cnt, flush_cnt);
    end
`endif
    #9;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_idle();
    pc = 32'h100; r1d = 32'h5; r2d = 32'h7; a1 = 5'd1; a2 = 5'd2; rd = 5'd3; rdwe = 1'b1;
    id_valid = 1'b1;
    tick();
    tests_run++;
    if (op1_o !== 32'h5 || op2_o !== 32'h7 || ex_valid !== 1'b1 || rdwe_o !== 1'b1 ||
        rd_o !== 5'd3 || pc_o !== 32'h100 || store_o !== 32'h7 || aop_o !== ALU_ADD) begin
      tests_failed++;
      $display("FAIL basic_add: op1=%h op2=%h v=%b we=%b rd=%0d pc=%h st=%h, required 5/7/1/1/3/100/7",
               op1_o, op2_o, ex_valid, rdwe_o, rd_o, pc_o, store_o);
    end
    // PC/imm sources, x0 destination suppresses write enable
    s1pc = 1'b1; s2imm = 1'b1; imm = 32'h44; aop = ALU_SUB; rd = 5'd0;
    tick();
    tests_run++;
    if (op1_o !== 32'h100 || op2_o !== 32'h44 || store_o !== 32'h7 || aop_o !== ALU_SUB || rdwe_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL pc_imm_src: op1=%h op2=%h st=%h op=%0d we=%b, required 100/44/7/SUB/0",
               op1_o, op2_o, store_o, aop_o, rdwe_o);
    end
  endtask

  task automatic test_forward();
    set_idle();
    r1d = 32'h5; r2d = 32'h7; a1 = 5'd1; a2 = 5'd2; id_valid = 1'b1;
    mfwe = 1'b1; mfa = 5'd1; mfd = 32'hAA; wfwe = 1'b1; wfa = 5'd1; wfd = 32'hBB;
    tick();
    tests_run++;
    if (op1_o !== 32'hAA || op2_o !== 32'h7) begin
      tests_failed++;
      $display("FAIL fwd_mem_wins: op1=%h op2=%h required aa/7", op1_o, op2_o);
    end
    mfwe = 1'b0;
    tick();
    tests_run++;
    if (op1_o !== 32'hBB) begin
      tests_failed++;
      $display("FAIL fwd_wb: op1=%h required bb", op1_o);
    end
    a1 = 5'd0; mfwe = 1'b1; mfa = 5'd0; wfa = 5'd0; wfa = 5'd2;
    tick();
    tests_run++;
    if (op1_o !== 32'h5 || op2_o !== 32'hBB || store_o !== 32'hBB) begin
      tests_failed++;
      $display("FAIL fwd_x0: op1=%h op2=%h st=%h required 5/bb/bb", op1_o, op2_o, store_o);
    end
  endtask

  task automatic test_hold_refresh(input logic use_imm);
    set_idle();
    tick();  // drain anything held
    r1d = 32'h5; r2d = 32'h7; a1 = 5'd1; a2 = 5'd2; rd = 5'd4; rdwe = 1'b1;
    s2imm = use_imm; imm = 32'h55; id_valid = 1'b1; ex_ready = 1'b0;
    tick();
    r2d = 32'h999;  // a new pending instruction must not be taken
    for (int c = 0; c < 3; c++) begin
      wfwe = (c == 1); wfa = 5'd2; wfd = 32'h1234;
      #1;
      tests_run++;
      if (id_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_ready: cycle %0d id_ready=%b required 0", c, id_ready);
      end
      tick();
    end
    wfwe = 1'b0;
    tests_run++;
    if (op2_o !== (use_imm ? 32'h55 : 32'h1234) || store_o !== 32'h1234 || op1_o !== 32'h5 || ex_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_refresh(imm=%b): op2=%h st=%h op1=%h v=%b", use_imm, op2_o, store_o, op1_o, ex_valid);
    end
    id_valid = 1'b0; ex_ready = 1'b1;
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || rdwe_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain: v=%b we=%b required 0/0", ex_valid, rdwe_o);
    end
  endtask

  task automatic test_flush();
    set_idle();
    tick();
    a1 = 5'd1; rd = 5'd5; rdwe = 1'b1; id_valid = 1'b1; ex_ready = 1'b0;
    tick();
    flush = 1'b1; r1d = 32'h77;
    #1;
    tests_run++;
    if (id_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_ready: id_ready=%b required 0", id_ready);
    end
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || rdwe_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_held: v=%b we=%b required 0/0", ex_valid, rdwe_o);
    end
    ex_ready = 1'b1;  // empty stage: id_ready=1 yet the incoming instr is dropped
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || rdwe_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_incoming: v=%b we=%b required 0/0", ex_valid, rdwe_o);
    end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_idle();
    a1 = 5'd1; a2 = 5'd2; rd = 5'd6; rdwe = 1'b1; id_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r1d = 32'h10 * i + 32'h1; r2d = 32'h20 * i + 32'h3; pc = 32'h200 + 32'h4 * i;
      tick();
      tests_run++;
      if (ex_valid !== 1'b1 || op1_o !== 32'h10 * i + 32'h1 || op2_o !== 32'h20 * i + 32'h3 ||
          pc_o !== 32'h200 + 32'h4 * i) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: v=%b op1=%h op2=%h pc=%h", i, ex_valid, op1_o, op2_o, pc_o);
      end
    end
  endtask

  task automatic test_async_reset();
    set_idle();
    a1 = 5'd1; r1d = 32'h9; rd = 5'd1; rdwe = 1'b1; id_valid = 1'b1; ex_ready = 1'b0;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ex_valid !== 1'b0 || rdwe_o !== 1'b0 || op1_o !== 32'd0 || aop_o !== ALU_ADD) begin
      tests_failed++;
      $display("FAIL async_reset: v=%b we=%b op1=%h op=%0d required 0/0/0/ADD", ex_valid, rdwe_o, op1_o, aop_o);
    end
    #10;
    set_idle();
    rst_n = 1'b1;
    tick();
  endtask

  // Reference operand value: the most recent in-flight producer of the
  // register wins (MEM is younger than WB), x0 reads as the regfile value.
  function automatic logic [31:0] ref_operand(input logic [4:0] r, input logic [31:0] base);
    logic [4:0]  p_addr [2];
    logic        p_we   [2];
    logic [31:0] p_data [2];
    p_addr[0] = mfa; p_we[0] = mfwe; p_data[0] = mfd;
    p_addr[1] = wfa; p_we[1] = wfwe; p_data[1] = wfd;
    if (r == 5'd0) return base;
    for (int k = 0; k < 2; k++) begin
      if (p_we[k] && p_addr[k] == r) return p_data[k];
    end
    return base;
  endfunction

  task automatic test_random(input int n);
    logic m_valid, m_we, m_reg1, m_reg2;
    logic [31:0] m_op1, m_op2, m_st, m_pc;
    logic [4:0] m_rd, m_a1, m_a2;
    alu_operation_t m_aop;
    logic exp_ready;
    do_reset();
    m_valid = 1'b0; m_we = 1'b0; m_reg1 = 1'b0; m_reg2 = 1'b0;
    m_op1 = 32'd0; m_op2 = 32'd0; m_st = 32'd0; m_pc = 32'd0;
    m_rd = 5'd0; m_a1 = 5'd0; m_a2 = 5'd0; m_aop = ALU_ADD;
    for (int c = 0; c < n; c++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      pc = $urandom; imm = $urandom; r1d = $urandom; r2d = $urandom;
      a1 = 5'($urandom_range(0, 3)); a2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      rdwe = 1'($urandom); s1pc = 1'($urandom); s2imm = 1'($urandom);
      aop = alu_operation_t'(4'($urandom_range(0, 9)));
      mfwe = 1'($urandom); mfa = 5'($urandom_range(0, 3)); mfd = $urandom;
      wfwe = 1'($urandom); wfa = 5'($urandom_range(0, 3)); wfd = $urandom;
      #1;
      exp_ready = !m_valid || ex_ready;
      tests_run++;
      if (id_ready !== exp_ready) begin
        tests_failed++;
        $display("FAIL rand_ready[%0d]: id_ready=%b required %b", c, id_ready, exp_ready);
      end
      if (flush) begin
        m_valid = 1'b0; m_we = 1'b0;
      end else if (id_valid && exp_ready) begin
        m_valid = 1'b1;
        m_st  = ref_operand(a2, r2d);
        m_op1 = s1pc ? pc : ref_operand(a1, r1d);
        m_op2 = s2imm ? imm : m_st;
        m_pc = pc; m_rd = rd; m_we = rdwe && (rd != 5'd0); m_aop = aop;
        m_a1 = a1; m_a2 = a2; m_reg1 = !s1pc; m_reg2 = !s2imm;
      end else if (m_valid && ex_ready) begin
        m_valid = 1'b0; m_we = 1'b0;
      end else if (m_valid) begin
        m_st = ref_operand(m_a2, m_st);
        if (m_reg1) m_op1 = ref_operand(m_a1, m_op1);
        if (m_reg2) m_op2 = ref_operand(m_a2, m_op2);
      end
      tick();
      tests_run++;
      if (ex_valid !== m_valid || rdwe_o !== m_we) begin
        tests_failed++;
        $display("FAIL rand_ctrl[%0d]: v=%b we=%b required %b/%b", c, ex_valid, rdwe_o, m_valid, m_we);
      end
      if (m_valid) begin
        tests_run++;
        if (op1_o !== m_op1 || op2_o !== m_op2 || store_o !== m_st || pc_o !== m_pc ||
            rd_o !== m_rd || aop_o !== m_aop) begin
          tests_failed++;
          $display("FAIL rand_data[%0d]: op1=%h/%h op2=%h/%h st=%h/%h pc=%h/%h rd=%0d/%0d op=%0d/%0d (got/required)",
                   c, op1_o, m_op1, op2_o, m_op2, store_o, m_st, pc_o, m_pc, rd_o, m_rd, aop_o, m_aop);
        end
      end
    end
    set_idle();
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf();
    do_reset();
    a1 = 5'd1; id_valid = 1'b1; ex_ready = 1'b0;
    tick();       // accepted; stage was empty at this edge
    id_valid = 1'b0;
    repeat (4) tick();
    flush = 1'b1; ex_ready = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (stall_cnt !== 32'd4 || flush_cnt !== 32'd1) begin
      tests_failed++;
      $display("FAIL perf_counts: stall=%0d flush=%0d required 4/1", stall_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    set_idle();
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_forward();
    test_hold_refresh(1'b0);
    test_hold_refresh(1'b1);
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random(400);
`ifdef ID_EX_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
